// File: rtl/mem_access_seq.sv
// Byte-serial load/store sequencer: LW/SW done in 6/5 cycles, LB/SB in 3/2; waits on grant_i, rdy=0 freezes all.
// Build option MISALIGN_CHECK_EN: misaligned H/W accesses finish with misalign_o and no memory traffic.
module mem_access_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        grant_i,
  input  logic [7:0]  ram_din_i,
  output logic        mem_request_o,
  output logic [31:0] mem_addr_o,
  output logic        write_o,
  output logic [7:0]  wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, LAST, DONE} state_t;

  state_t      state;
  logic [2:0]  op_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  k;
  logic        cap_vld;
  logic [1:0]  cap_k;
  logic [31:0] ld_buf;
  logic [31:0] full;
  logic [31:0] ext;
  logic [1:0]  last_k;
  logic        skip;
  logic        req_act;

`ifdef MISALIGN_CHECK_EN
  logic mis_r;
  assign skip = mis_r;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    case (op_r[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Buffer with the byte arriving this cycle merged in, so the final byte can be extended on the LAST edge
  always_comb begin
    full = ld_buf;
    if (cap_vld)
      full[{cap_k, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    case (op_r)
      3'b000:  ext = {{24{full[7]}}, full[7:0]};
      3'b001:  ext = {{16{full[15]}}, full[15:0]};
      3'b100:  ext = {24'd0, full[7:0]};
      3'b101:  ext = {16'd0, full[15:0]};
      default: ext = full;
    endcase
  end

  assign req_act       = rdy && (state == ISSUE) && !skip;
  assign mem_request_o = req_act;
  assign mem_addr_o    = req_act ? (addr_r + {30'd0, k}) : 32'd0;
  assign write_o       = req_act && we_r;
  assign wdata_o       = (req_act && we_r) ? wdata_r[{k, 3'b000} +: 8] : 8'd0;
  assign busy_o        = (state == ISSUE) || (state == LAST);
  assign done_o        = rdy && (state == DONE);
  assign misalign_o    = done_o && skip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= 3'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      k       <= 2'd0;
      cap_vld <= 1'b0;
      cap_k   <= 2'd0;
      ld_buf  <= 32'd0;
      rdata_o <= 32'd0;
`ifdef MISALIGN_CHECK_EN
      mis_r   <= 1'b0;
`endif
    end else if (rdy) begin
      // A byte read under grant arrives one cycle later whatever grant_i does then
      cap_vld <= 1'b0;
      if (cap_vld)
        ld_buf <= full;
      case (state)
        IDLE: begin
          if (start_i) begin
            op_r    <= op_i;
            we_r    <= we_i;
            addr_r  <= addr_i;
            wdata_r <= wdata_i;
            k       <= 2'd0;
`ifdef MISALIGN_CHECK_EN
            mis_r   <= (op_i[1:0] == 2'b01 && addr_i[0]) ||
                       (op_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
`endif
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (skip) begin
            state <= DONE;
          end else if (grant_i) begin
            cap_vld <= !we_r;
            cap_k   <= k;
            if (k == last_k)
              state <= we_r ? DONE : LAST;
            else
              k <= k + 2'd1;
          end
        end
        LAST: begin
          rdata_o <= ext;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomised and directed bench for mem_access_seq with a byte-addressed memory model and a scoreboard.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst, rdy, start_i, we_i, grant_i;
  logic [2:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic [7:0]  ram_din_i;
  logic        mem_request_o, write_o, busy_o, done_o, misalign_o;
  logic [31:0] mem_addr_o, rdata_o;
  logic [7:0]  wdata_o;

  mem_access_seq dut (
    .clk(clk), .rst(rst), .rdy(rdy), .start_i(start_i), .op_i(op_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .grant_i(grant_i), .ram_din_i(ram_din_i),
    .mem_request_o(mem_request_o), .mem_addr_o(mem_addr_o), .write_o(write_o),
    .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic wr; logic [7:0] dat; } traf_t;
  typedef struct { logic [31:0] rdata; int lat; logic mis; } res_t;

  traf_t traf_q[$];
  res_t  res_q[$];
  logic [7:0] ref_mem  [logic [31:0]];
  logic [7:0] phys_mem [logic [31:0]];
  logic [7:0] ram_next = 8'd0;
  logic [31:0] last_rd = 32'd0;
  int cyc = 0, start_cyc = 0, n_chk = 0, n_fail = 0;
  bit done_seen = 0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ref_mem[a]  = d;
    phys_mem[a] = d;
  endtask

  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 ram_din_i = ram_next;
  end

  // Monitor: bus rules, per-byte traffic and completions against the scoreboard; then the RAM itself
  always @(negedge clk) begin
    traf_t t;
    res_t  r;
    if (!rst) begin
      if (!mem_request_o) begin
        chk("idle_addr_zero", mem_addr_o, 32'd0);
        chk("idle_wr_zero", {23'd0, write_o, wdata_o}, 32'd0);
      end
      if (!rdy) chk("freeze_req", {30'd0, mem_request_o, write_o}, 32'd0);
      if (mem_request_o && grant_i && rdy) begin
        if (traf_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_request: got addr %h expected none", mem_addr_o);
        end else begin
          t = traf_q.pop_front();
          chk("req_addr", mem_addr_o, t.addr);
          chk("req_wr_dat", {23'd0, write_o, wdata_o}, {23'd0, t.wr, t.dat});
        end
      end
      if (done_o) begin
        done_seen = 1;
        if (res_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done_o 1 expected 0");
        end else begin
          r = res_q.pop_front();
          chk("rdata", rdata_o, r.rdata);
          chk("misalign", {31'd0, misalign_o}, {31'd0, r.mis});
          chk("busy_at_done", {31'd0, busy_o}, 32'd0);
          chk("bytes_left", traf_q.size(), 32'd0);
          if (r.lat >= 0) chk("latency", cyc - start_cyc, r.lat);
        end
      end else begin
        chk("misalign_quiet", {31'd0, misalign_o}, 32'd0);
      end
    end
    if (!rst && rdy) begin
      if (mem_request_o && write_o && grant_i) phys_mem[mem_addr_o] = wdata_o;
      ram_next = phys_rd(mem_addr_o);
    end
  end

  task automatic run_txn(input logic [2:0] op, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input bit rnd, input logic [31:0] gmask,
                         input logic [31:0] rmask, input int lat);
    int n, rel;
    logic [31:0] v, a;
    bit mis;
    traf_t t;
    res_t r;
    n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    mis = 0;
`ifdef MISALIGN_CHECK_EN
    mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`endif
    v = 32'd0;
    if (!mis) begin
      for (int i = 0; i < n; i++) begin
        a = addr + i;
        if (we) begin
          t = '{a, 1'b1, wd[8*i +: 8]};
          ref_mem[a] = wd[8*i +: 8];
        end else begin
          t = '{a, 1'b0, 8'd0};
          v[8*i +: 8] = ref_rd(a);
        end
        traf_q.push_back(t);
      end
      if (!we) begin
        if (n < 4 && !op[2] && v >= (32'd1 << (8*n - 1))) v = v - (32'd1 << (8*n));
        last_rd = v;
      end
    end
    r = '{last_rd, lat, mis};
    res_q.push_back(r);
    done_seen = 0;
    @(posedge clk); #1;
    start_cyc = cyc;
    start_i = 1'b1; op_i = op; we_i = we; addr_i = addr; wdata_i = wd; rdy = 1'b1;
    grant_i = rnd ? 1'($urandom_range(0, 1)) : !gmask[0];
    forever begin
      @(posedge clk); #1;
      if (done_seen) break;
      rel = cyc - start_cyc;
      if (rel > 300) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: got no done_o after %0d cycles expected completion", rel);
        break;
      end
      start_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      op_i = 3'($urandom); we_i = 1'($urandom_range(0, 1));
      addr_i = $urandom; wdata_i = $urandom;
      if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
        grant_i = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = (rel < 32) ? !rmask[rel] : 1'b1;
        grant_i = (rel < 32) ? !gmask[rel] : 1'b1;
      end
    end
    start_i = 1'b0; rdy = 1'b1; grant_i = 1'b1;
  endtask

  // LW aborted by reset after two bytes; only those two bytes may appear on the bus
  task automatic run_abort();
    traf_q.push_back('{32'h100, 1'b0, 8'd0});
    traf_q.push_back('{32'h101, 1'b0, 8'd0});
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'b010; we_i = 1'b0; addr_i = 32'h100; rdy = 1'b1; grant_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    last_rd = 32'd0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_req", {31'd0, mem_request_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_rdata", rdata_o, 32'd0);
    chk("abort_traffic", traf_q.size(), 32'd0);
  endtask

  initial begin
    logic [2:0] ops [5];
    logic [31:0] ra;
    int sel;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;
    rst = 1'b1; rdy = 1'b1; start_i = 1'b1; op_i = 3'b010; we_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0; grant_i = 1'b1; ram_din_i = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, mem_request_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_write", {31'd0, write_o}, 32'd0);
    chk("rst_wdata", {24'd0, wdata_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    @(posedge clk); #1; rst = 1'b0; start_i = 1'b0;

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h300, 8'h80);
    preload(32'h310, 8'h34); preload(32'h311, 8'hF2);

    run_txn(3'b010, 1'b0, 32'h100, 32'd0, 0, 32'd0, 32'd0, 6);
    run_txn(3'b000, 1'b0, 32'h300, 32'd0, 0, 32'd0, 32'd0, 3);
    run_txn(3'b100, 1'b0, 32'h300, 32'd0, 0, 32'd0, 32'd0, 3);
    run_txn(3'b101, 1'b0, 32'h310, 32'd0, 0, 32'd0, 32'd0, 4);
    run_txn(3'b010, 1'b1, 32'h200, 32'hDEADBEEF, 0, 32'h0000000C, 32'd0, 7);
    run_txn(3'b010, 1'b0, 32'h200, 32'd0, 0, 32'd0, 32'd0, 6);
    run_txn(3'b000, 1'b1, 32'h204, 32'h000000A7, 0, 32'd0, 32'd0, 2);
    run_txn(3'b010, 1'b1, 32'h208, 32'h11223344, 0, 32'd0, 32'd0, 5);
    run_txn(3'b001, 1'b0, 32'h310, 32'd0, 0, 32'd0, 32'h0000001C, 7);
    run_txn(3'b010, 1'b1, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 32'd0, 32'd0, -1);
    run_txn(3'b010, 1'b0, 32'hFFFFFFFE, 32'd0, 0, 32'd0, 32'd0, -1);
`ifdef MISALIGN_CHECK_EN
    run_txn(3'b010, 1'b0, 32'h102, 32'd0, 0, 32'd0, 32'd0, 2);
`else
    run_txn(3'b010, 1'b0, 32'h102, 32'd0, 0, 32'd0, 32'd0, 6);
`endif
    run_abort();
    run_txn(3'b010, 1'b0, 32'h100, 32'd0, 0, 32'd0, 32'd0, 6);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) ra = ra | 32'hFFFFFFC0;
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 2);
        run_txn(ops[sel], 1'b1, ra, $urandom, 1, 32'd0, 32'd0, -1);
      end else begin
        sel = $urandom_range(0, 4);
        run_txn(ops[sel], 1'b0, ra, 32'd0, 1, 32'd0, 32'd0, -1);
      end
    end

    repeat (3) @(posedge clk);
    chk("final_results_drained", res_q.size(), 32'd0);
    chk("final_traffic_drained", traf_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
